// File: rtl/sp_dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory with
// 1-cycle read latency. Port 0 is the core load/store unit, port 1 the host.
// Only one read is in flight at a time; out-of-range requests never reach the
// memory, are counted, and out-of-range reads answer with an error response.
module sp_dmem_arbiter #(
  parameter int unsigned AW    = 12,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rq_valid_0,
  input  logic          rq_we_0,
  input  logic [AW-1:0] rq_addr_0,
  input  logic [DW-1:0] rq_wdata_0,
  output logic          rq_ready_0,
  output logic          rs_valid_0,
  output logic [DW-1:0] rs_rdata_0,
  output logic          rs_err_0,
  input  logic          rq_valid_1,
  input  logic          rq_we_1,
  input  logic [AW-1:0] rq_addr_1,
  input  logic [DW-1:0] rq_wdata_1,
  output logic          rq_ready_1,
  output logic          rs_valid_1,
  output logic [DW-1:0] rs_rdata_1,
  output logic          rs_err_1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [CW-1:0] conflict_cnt,
  output logic [CW-1:0] err_cnt
);

  typedef enum logic [0:0] {StIdle, StRdWait} state_e;

  // One extra bit so DEPTH == 2^AW is representable and nothing is out of range.
  localparam logic [AW:0] DepthLim = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] CntMax = {CW{1'b1}};

  state_e        state_q;
  logic          last_grant_q;
  logic          owner_q;
  logic          oor_q;
  logic [CW-1:0] conflict_q;
  logic [CW-1:0] err_q;

  logic          in_idle, in_wait;
  logic          grant_0, grant_1, accept, sel;
  logic          sel_we, sel_oor;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Arbitration and memory strobe; everything is held off while in reset.
  always_comb begin
    in_idle   = (state_q == StIdle) && !rst;
    in_wait   = (state_q == StRdWait) && !rst;
    grant_0   = in_idle && rq_valid_0 && (!rq_valid_1 || last_grant_q);
    grant_1   = in_idle && rq_valid_1 && (!rq_valid_0 || !last_grant_q);
    accept    = grant_0 || grant_1;
    sel       = grant_1;
    sel_we    = sel ? rq_we_1 : rq_we_0;
    sel_addr  = sel ? rq_addr_1 : rq_addr_0;
    sel_wdata = sel ? rq_wdata_1 : rq_wdata_0;
    sel_oor   = ({1'b0, sel_addr} >= DepthLim);

    rq_ready_0 = grant_0;
    rq_ready_1 = grant_1;
    mem_en     = accept && !sel_oor;
    mem_we     = mem_en && sel_we;
    mem_addr   = mem_en ? sel_addr : '0;
    mem_wdata  = mem_en ? sel_wdata : '0;
  end

  // Read response steered to the owner; the other port sees all zeros.
  always_comb begin
    rs_valid_0 = in_wait && !owner_q;
    rs_valid_1 = in_wait && owner_q;
    rs_err_0   = rs_valid_0 && oor_q;
    rs_err_1   = rs_valid_1 && oor_q;
    rs_rdata_0 = (rs_valid_0 && !oor_q) ? mem_rdata : '0;
    rs_rdata_1 = (rs_valid_1 && !oor_q) ? mem_rdata : '0;
  end

  // Controller state, round-robin pointer, read ownership and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      oor_q        <= 1'b0;
      conflict_q   <= '0;
      err_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rq_valid_0 && rq_valid_1 && conflict_q != CntMax) begin
            conflict_q <= conflict_q + CW'(1);
          end
          if (accept) begin
            last_grant_q <= sel;
            if (sel_oor && err_q != CntMax) begin
              err_q <= err_q + CW'(1);
            end
            if (!sel_we) begin
              owner_q <= sel;
              oor_q   <= sel_oor;
              state_q <= StRdWait;
            end
          end
        end
        StRdWait: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign conflict_cnt = conflict_q;
  assign err_cnt      = err_q;

endmodule
